// File: rtl/sdp_ram_burst_reader.sv
// rtl/sdp_ram_burst_reader.sv - burst read engine for a registered-output SDP RAM
// Sweeps a wrapping address range and streams the words through a 2-entry skid FIFO.
module sdp_ram_burst_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_ena,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   issue_cnt, ret_cnt;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  rd_ptr, wr_ptr;
  logic                  done_q, done_next;
  logic                  accept, pop, push;
  logic [2:0]            level, limit;

  assign pop           = m_valid & m_ready;
  assign push          = inflight;
  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign ram_read_addr = addr_q;
  assign m_valid       = (occ != 2'd0);
  assign m_data        = mem[rd_ptr];

  // Words already committed (buffered or in flight) after this cycle's pop must leave room.
  assign level = {1'b0, occ} + {2'b00, inflight};
  assign limit = 3'd2 + {2'b00, pop};

  always_comb begin
    state_next = state;
    ram_ena    = 1'b0;
    accept     = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept     = 1'b1;
            state_next = RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if ((issue_cnt != '0) && (level < limit)) begin
          ram_ena = 1'b1;
          if (issue_cnt == CNT_ONE) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (ret_cnt == CNT_ONE)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      addr_q    <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else begin
      state    <= state_next;
      done_q   <= done_next;
      inflight <= ram_ena;
      if (accept) begin
        addr_q    <= start_addr;
        issue_cnt <= length;
        ret_cnt   <= length;
      end
      if (ram_ena) begin
        addr_q    <= addr_q + 1'b1;
        issue_cnt <= issue_cnt - CNT_ONE;
      end
      if (pop) begin
        ret_cnt <= ret_cnt - CNT_ONE;
        rd_ptr  <= ~rd_ptr;
      end
      if (push) begin
        mem[wr_ptr] <= ram_dout;
        wr_ptr      <= ~wr_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_sdp_ram_burst_reader.sv
// tb/tb_sdp_ram_burst_reader.sv - self-checking bench for sdp_ram_burst_reader
// Expected words come from the bench-owned RAM contents indexed by (start_addr+i) mod depth.
module tb_sdp_ram_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [10:0] length = '0;
  logic        busy, done, ram_ena, m_valid;
  logic        m_ready = 1'b1;
  logic [9:0]  ram_read_addr;
  logic [31:0] ram_dout = '0;
  logic [31:0] m_data;

  logic [31:0] ram_mem [1024];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [31:0] got_q[$];
  logic [9:0]  addr_q[$];
  int first_valid, done_rel, done_cnt, ena_cnt, stab_err, max_out, timed_out;

  sdp_ram_burst_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .ram_ena(ram_ena), .ram_read_addr(ram_read_addr),
    .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_ena) ram_dout <= ram_mem[ram_read_addr];

  // Caller must be at posedge+#1. Observations are taken at negedge; rel = cycles after acceptance edge.
  task automatic run_cmd(input int a, input int n, input bit rnd, input int inject_rel,
                         input int abort_after, input int max_cyc);
    int rel, issued, popped;
    logic pv, pr;
    logic [31:0] pd;
    got_q.delete(); addr_q.delete();
    first_valid = -1; done_rel = -1; done_cnt = 0; ena_cnt = 0;
    stab_err = 0; max_out = 0; timed_out = 0;
    issued = 0; popped = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    start = 1'b1; start_addr = 10'(a); length = 11'(n);
    @(posedge clk); #1;
    start = 1'b0;
    rel = 1;
    forever begin
      @(negedge clk);
      if (issued - popped > max_out) max_out = issued - popped;
      if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd)) stab_err++;
      if (ram_ena === 1'b1) begin ena_cnt++; addr_q.push_back(ram_read_addr); issued++; end
      if (m_valid === 1'b1 && first_valid < 0) first_valid = rel;
      if (m_valid === 1'b1 && m_ready) begin got_q.push_back(m_data); popped++; end
      if (done === 1'b1) begin done_cnt++; if (done_rel < 0) done_rel = rel; end
      pv = m_valid; pr = m_ready; pd = m_data;
      if (done_rel >= 0 && rel >= done_rel + 2) break;
      if (abort_after > 0 && got_q.size() >= abort_after) break;
      if (rel >= max_cyc) begin timed_out = 1; break; end
      @(posedge clk); #1;
      if (rel + 1 == inject_rel) begin
        start = 1'b1; start_addr = 10'd777; length = 11'd7;
      end else begin
        start = 1'b0;
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rel++;
    end
    if (abort_after == 0) begin
      @(posedge clk); #1;
      start = 1'b0; m_ready = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (ram_ena !== 1'b0) begin bad++; $display("FAIL reset_ena got=%b want=0", ram_ena); end
    total++; if (ram_read_addr !== 10'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", ram_read_addr); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    total++; if (m_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", m_data); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_burst(input string nm, input int a, input int n);
    int errs_w, errs_a;
    logic [9:0] ea;
    errs_w = 0; errs_a = 0;
    total++; if (timed_out != 0) begin bad++; $display("FAIL %s_timeout got=%0d want=0", nm, timed_out); end
    total++; if (got_q.size() != n) begin bad++; $display("FAIL %s_count got=%0d want=%0d", nm, got_q.size(), n); end
    total++; if (addr_q.size() != n) begin bad++; $display("FAIL %s_issues got=%0d want=%0d", nm, addr_q.size(), n); end
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      ea = 10'(a + i);
      if (got_q[i] !== ram_mem[ea]) errs_w++;
    end
    for (int i = 0; i < n && i < addr_q.size(); i++) begin
      ea = 10'(a + i);
      if (addr_q[i] !== ea) errs_a++;
    end
    total++; if (errs_w != 0) begin bad++; $display("FAIL %s_words got=%0d_mismatches want=0", nm, errs_w); end
    total++; if (errs_a != 0) begin bad++; $display("FAIL %s_addrs got=%0d_mismatches want=0", nm, errs_a); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done_pulses got=%0d want=1", nm, done_cnt); end
  endtask

  task automatic test_full_512;
    run_cmd(0, 512, 1'b0, 0, 0, 700);
    check_burst("b512", 0, 512);
    total++; if (first_valid != 3) begin bad++; $display("FAIL b512_first_valid got=%0d want=3", first_valid); end
    total++; if (done_rel != 515) begin bad++; $display("FAIL b512_done_cycle got=%0d want=515", done_rel); end
  endtask

  task automatic test_wrap;
    run_cmd(1020, 8, 1'b0, 0, 0, 100);
    check_burst("wrap", 1020, 8);
    total++; if (done_rel != 11) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=11", done_rel); end
  endtask

  task automatic test_random_ready;
    for (int k = 0; k < 3; k++) begin
      int a;
      a = int'($urandom_range(0, 1023));
      run_cmd(a, 16, 1'b1, 0, 0, 400);
      check_burst("rnd", a, 16);
      total++; if (stab_err != 0) begin bad++; $display("FAIL rnd_stable got=%0d want=0", stab_err); end
      total++; if (max_out > 2) begin bad++; $display("FAIL rnd_occupancy got=%0d want<=2", max_out); end
    end
  endtask

  task automatic test_len0_and_ignore;
    run_cmd(5, 0, 1'b0, 0, 0, 20);
    total++; if (done_rel != 1) begin bad++; $display("FAIL len0_done_cycle got=%0d want=1", done_rel); end
    total++; if (ena_cnt != 0) begin bad++; $display("FAIL len0_ena got=%0d want=0", ena_cnt); end
    total++; if (first_valid != -1) begin bad++; $display("FAIL len0_valid got=%0d want=-1", first_valid); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL len0_done_pulses got=%0d want=1", done_cnt); end
    run_cmd(40, 4, 1'b0, 2, 0, 60);
    check_burst("ignore", 40, 4);
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    int saw_done;
    run_cmd(300, 20, 1'b0, 0, 5, 100);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (ram_ena !== 1'b0) begin bad++; $display("FAIL mid_ena got=%b want=0", ram_ena); end
    total++; if (ram_read_addr !== 10'd0) begin bad++; $display("FAIL mid_addr got=%0d want=0", ram_read_addr); end
    total++; if (m_valid !== 1'b0 || m_data !== 32'd0) begin bad++; $display("FAIL mid_stream got=%b/%h want=0/0", m_valid, m_data); end
    saw_done = 0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) saw_done++; end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin @(negedge clk); if (done !== 1'b0) saw_done++; end
    total++; if (saw_done != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", saw_done); end
    @(posedge clk); #1;
    run_cmd(50, 3, 1'b0, 0, 0, 40);
    check_burst("after_rst", 50, 3);
    total++; if (done_rel != 6) begin bad++; $display("FAIL after_rst_done_cycle got=%0d want=6", done_rel); end
  endtask

  task automatic test_full_1024;
    run_cmd(512, 1024, 1'b0, 0, 0, 1200);
    check_burst("b1024", 512, 1024);
    total++; if (done_rel != 1027) begin bad++; $display("FAIL b1024_done_cycle got=%0d want=1027", done_rel); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      ram_mem[i] = (i < 512) ? 32'(i) * 32'h0101_0101 : $urandom;
    test_reset;
    test_full_512;
    test_wrap;
    test_random_ready;
    test_len0_and_ignore;
    test_reset_mid;
    test_full_1024;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
